// File: rtl/alu_uart_master.sv
// alu_uart_master
//   Host-side initiator of the ALU-over-UART protocol. It accepts one request
//   and writes three bytes (A, B, OP) into a uart_core TX FIFO. It then waits
//   for one result byte from the RX FIFO, or gives up after TIMEOUT cycles.
//
// Ports
//   clk_i, reset_ni            clock, synchronous active-low reset
//   req_valid_i/req_ready_o    request handshake (ready only in IDLE)
//   req_a_i, req_b_i, req_op_i operands and opcode, latched on accept
//   rsp_valid_o, rsp_data_o    registered result pulse and last result byte
//   rsp_timeout_o              registered pulse when no result arrived in time
//   busy_o                     transaction in progress
//   wr_uart_o, w_data_o        TX FIFO push strobe and byte
//   tx_full_i                  TX FIFO full
//   rd_uart_o                  RX FIFO pop; r_data_i is show-ahead
//   r_data_i, rx_empty_i       RX FIFO head byte and empty flag
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | ready for a request; drains stale RX bytes
// SEND_A   | push operand A when the TX FIFO has room
// SEND_B   | push operand B when the TX FIFO has room
// SEND_OP  | push zero-extended opcode, then restart timeout
// WAIT_RES | wait for the result byte or the timeout
module alu_uart_master #(
  parameter int DBIT    = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 2000000,
  parameter int TO_BITS = 21
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [DBIT-1:0] req_a_i,
  input  logic [DBIT-1:0] req_b_i,
  input  logic [OP_W-1:0] req_op_i,
  output logic            rsp_valid_o,
  output logic [DBIT-1:0] rsp_data_o,
  output logic            rsp_timeout_o,
  output logic            busy_o,
  output logic            wr_uart_o,
  output logic [DBIT-1:0] w_data_o,
  input  logic            tx_full_i,
  output logic            rd_uart_o,
  input  logic [DBIT-1:0] r_data_i,
  input  logic            rx_empty_i
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES
  } state_t;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DBIT-1:0]     a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [TO_BITS-1:0]  cnt_q, cnt_d;
  logic [DBIT-1:0]     rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                sending;

  assign sending     = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == SEND_OP);
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wr_uart_o   = sending && !tx_full_i;
  // IDLE pops too, so a result that arrives after an abort is thrown away.
  assign rd_uart_o   = ((state_q == IDLE) || (state_q == WAIT_RES)) && !rx_empty_i;

  always_comb begin
    case (state_q)
      SEND_A:  w_data_o = a_q;
      SEND_B:  w_data_o = b_q;
      SEND_OP: w_data_o = DBIT'(op_q);
      default: w_data_o = '0;
    endcase
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign rsp_data_o    = rsp_data_q;

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d     = req_a_i;
          b_d     = req_b_i;
          op_d    = req_op_i;
          state_d = SEND_A;
        end
      end
      SEND_A:  if (!tx_full_i) state_d = SEND_B;
      SEND_B:  if (!tx_full_i) state_d = SEND_OP;
      SEND_OP: begin
        if (!tx_full_i) begin
          cnt_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        cnt_d = cnt_q + 1'b1;
        // A byte in the same cycle as the last timeout count takes priority.
        if (!rx_empty_i) begin
          rsp_data_d  = r_data_i;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == TO_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_alu_uart_master.sv
module tb_alu_uart_master;
  localparam int DBIT    = 8;
  localparam int OP_W    = 6;
  localparam int TIMEOUT = 16;
  localparam int TO_BITS = 5;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic [DBIT-1:0] req_a_i = '0;
  logic [DBIT-1:0] req_b_i = '0;
  logic [OP_W-1:0] req_op_i = '0;
  logic            tx_full_i = 1'b0;
  logic [DBIT-1:0] r_data_i = '0;
  logic            rx_empty_i = 1'b1;
  logic            req_ready_o, rsp_valid_o, rsp_timeout_o, busy_o, wr_uart_o, rd_uart_o;
  logic [DBIT-1:0] rsp_data_o, w_data_o;

  alu_uart_master #(.DBIT(DBIT), .OP_W(OP_W), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o), .wr_uart_o(wr_uart_o), .w_data_o(w_data_o), .tx_full_i(tx_full_i),
    .rd_uart_o(rd_uart_o), .r_data_i(r_data_i), .rx_empty_i(rx_empty_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] d; bit is_op; int exp_cyc; } push_t;
  typedef struct { bit to; logic [7:0] d; bit chk_gap; } rsp_t;

  push_t      push_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] rx_q[$];

  int total = 0, bad = 0;
  int cyc = 0, npush = 0, nrsp = 0, nrd = 0, op_cyc = 0;
  bit rd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void rx_update();
    rx_empty_i = (rx_q.size() == 0);
    r_data_i   = rx_empty_i ? 8'h00 : rx_q[0];
  endfunction

  // RX FIFO model: pop one byte after every cycle in which rd_uart was high.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    if (rd_seen) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      rd_seen = 0;
      rx_update();
    end
  end

  // Monitor: checks pushes and responses against the expectation queues.
  always @(negedge clk_i) begin
    push_t p;
    rsp_t  r;
    if (rd_uart_o) begin
      rd_seen = 1;
      nrd++;
    end
    if (tx_full_i) check("wr_while_full", {31'b0, wr_uart_o}, 32'd0);
    if (wr_uart_o) begin
      npush++;
      if (push_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_push: got %0h expected none", w_data_o);
      end else begin
        p = push_q.pop_front();
        check("push_data", {24'b0, w_data_o}, {24'b0, p.d});
        if (p.exp_cyc >= 0) check("push_cycle", cyc, p.exp_cyc);
        if (p.is_op) op_cyc = cyc;
      end
    end
    if (rsp_valid_o || rsp_timeout_o) begin
      nrsp++;
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got valid=%0b timeout=%0b data=%0h expected none",
                 rsp_valid_o, rsp_timeout_o, rsp_data_o);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_timeout", {31'b0, rsp_timeout_o}, {31'b0, r.to});
        check("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, !r.to});
        check("rsp_data", {24'b0, rsp_data_o}, {24'b0, r.d});
        check("ready_at_rsp", {31'b0, req_ready_o}, 32'd1);
        // OP push in cycle p; WAIT_RES counts 0..TIMEOUT-1 in p+1..p+TIMEOUT.
        if (r.chk_gap) check("timeout_gap", cyc - op_cyc, TIMEOUT + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          input bit chk_lat);
    int guard = 0;
    int acc;
    req_valid_i = 1; req_a_i = a; req_b_i = b; req_op_i = op;
    while (!req_ready_o && guard < 50) begin tick(); guard++; end
    check("req_ready_wait", {31'b0, req_ready_o}, 32'd1);
    acc = cyc;
    push_q.push_back('{a, 1'b0, chk_lat ? acc + 1 : -1});
    push_q.push_back('{b, 1'b0, chk_lat ? acc + 2 : -1});
    push_q.push_back('{{2'b00, op}, 1'b1, chk_lat ? acc + 3 : -1});
    tick();
    req_valid_i = 0;
  endtask

  task automatic wait_pushes(input int target);
    int guard = 0;
    while (npush < target && guard < 100) begin tick(); guard++; end
    check("push_wait", {31'b0, npush >= target}, 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    int guard = 0;
    while (nrsp < target && guard < 100) begin tick(); guard++; end
    check("rsp_wait", {31'b0, nrsp >= target}, 32'd1);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_q.push_back(d);
    rx_update();
  endtask

  initial begin
    int n0, r0, d0;
    // Reset state
    reset_ni = 0;
    tick(); tick();
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_wr", {31'b0, wr_uart_o}, 32'd0);
    check("rst_rd", {31'b0, rd_uart_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rsp_timeout", {31'b0, rsp_timeout_o}, 32'd0);
    check("rst_rsp_data", {24'b0, rsp_data_o}, 32'd0);
    reset_ni = 1;
    tick();

    // T1 basic
    n0 = npush; r0 = nrsp;
    send_req(8'h05, 8'h03, 6'h20, 1);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    wait_pushes(n0 + 3);
    rsp_q.push_back('{1'b0, 8'h08, 1'b0});
    rx_push(8'h08);
    wait_rsp(r0 + 1);
    tick();

    // T2 backpressure while in SEND_B
    n0 = npush; r0 = nrsp;
    send_req(8'h11, 8'h22, 6'h33, 0);
    tick();
    tx_full_i = 1;
    repeat (5) tick();
    check("t2_held_pushes", npush - n0, 1);
    tx_full_i = 0;
    wait_pushes(n0 + 3);
    rsp_q.push_back('{1'b0, 8'h44, 1'b0});
    rx_push(8'h44);
    wait_rsp(r0 + 1);
    check("t2_push_total", npush - n0, 3);

    // T3 timeout, rsp_data keeps 0x44
    n0 = npush; r0 = nrsp;
    send_req(8'h01, 8'h02, 6'h03, 1);
    wait_pushes(n0 + 3);
    rsp_q.push_back('{1'b1, 8'h44, 1'b1});
    wait_rsp(r0 + 1);
    tick();

    // T4 byte arrives on the last timeout count
    n0 = npush; r0 = nrsp;
    send_req(8'h0F, 8'hF0, 6'h3F, 1);
    wait_pushes(n0 + 3);
    while (cyc < op_cyc + TIMEOUT) tick();
    rsp_q.push_back('{1'b0, 8'hAA, 1'b0});
    rx_push(8'hAA);
    wait_rsp(r0 + 1);
    tick();

    // T5 stale drain, then a clean request
    d0 = nrd; r0 = nrsp;
    rx_push(8'h5A);
    rx_push(8'h6B);
    tick(); tick(); tick();
    check("t5_rd_count", nrd - d0, 2);
    check("t5_drained", rx_q.size(), 0);
    check("t5_no_rsp", nrsp - r0, 0);
    n0 = npush;
    send_req(8'h07, 8'h08, 6'h09, 1);
    wait_pushes(n0 + 3);
    rsp_q.push_back('{1'b0, 8'h0F, 1'b0});
    rx_push(8'h0F);
    wait_rsp(r0 + 1);
    tick();

    // T6 reset during WAIT_RES, late byte drained
    n0 = npush; r0 = nrsp;
    send_req(8'h0A, 8'h0B, 6'h0C, 1);
    wait_pushes(n0 + 3);
    tick(); tick();
    reset_ni = 0;
    tick();
    reset_ni = 1;
    check("t6_idle", {31'b0, req_ready_o}, 32'd1);
    check("t6_busy", {31'b0, busy_o}, 32'd0);
    check("t6_rsp_data", {24'b0, rsp_data_o}, 32'd0);
    rx_push(8'h77);
    tick(); tick(); tick();
    check("t6_drained", rx_q.size(), 0);
    check("t6_no_rsp", nrsp - r0, 0);

    check("rsp_queue_empty", rsp_q.size(), 0);
    check("push_queue_empty", push_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
